// File: rtl/mem_interface_unit.sv
// Bridges TinyALU IU load/store requests onto a byte-wide req/ack memory bus.
// Loads return one byte; stores split the 16-bit result into two little-endian byte writes.
module mem_interface_unit #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  store,
    input  logic [ADDR_W-1:0]     Addr,
    input  logic [2*DATA_W-1:0]   result,
    output logic [DATA_W-1:0]     data,
    output logic                  mem_done,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack,
    output logic                  err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, RD, WR_LO, WR_HI, DONE} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [ADDR_W-1:0]   cap_addr, cap_addr_nxt;
    logic [DATA_W-1:0]   cap_hi, cap_hi_nxt;
    logic [DATA_W-1:0]   data_nxt;
    logic                req_nxt, we_nxt, err_nxt, done_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   wdata_nxt;
    logic                timed_out;

    // Byte address of the high half of a store; wraps at the top of memory.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

    assign timed_out = (cnt == CNT_LAST);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        cap_addr_nxt = cap_addr;
        cap_hi_nxt   = cap_hi;
        data_nxt     = data;
        req_nxt      = mem_req;
        we_nxt       = mem_we;
        addr_nxt     = mem_addr;
        wdata_nxt    = mem_wdata;
        err_nxt      = err;
        done_nxt     = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (load) begin
                    cap_addr_nxt = Addr;
                    req_nxt      = 1'b1;
                    we_nxt       = 1'b0;
                    addr_nxt     = Addr;
                    err_nxt      = err | store;
                    state_nxt    = RD;
                end else if (store) begin
                    cap_addr_nxt = Addr;
                    cap_hi_nxt   = result[2*DATA_W-1:DATA_W];
                    req_nxt      = 1'b1;
                    we_nxt       = 1'b1;
                    addr_nxt     = Addr;
                    wdata_nxt    = result[DATA_W-1:0];
                    state_nxt    = WR_LO;
                end
            end
            RD: begin
                if (mem_ack) begin
                    data_nxt  = mem_rdata;
                    req_nxt   = 1'b0;
                    state_nxt = DONE;
                end else if (timed_out) begin
                    data_nxt  = {DATA_W{1'b1}};
                    req_nxt   = 1'b0;
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            WR_LO: begin
                if (mem_ack) begin
                    addr_nxt  = addr_inc(cap_addr);
                    wdata_nxt = cap_hi;
                    cnt_nxt   = '0;
                    state_nxt = WR_HI;
                end else if (timed_out) begin
                    req_nxt   = 1'b0;
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            WR_HI: begin
                if (mem_ack || timed_out) begin
                    req_nxt   = 1'b0;
                    err_nxt   = err | ~mem_ack;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                req_nxt   = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // mem_done is registered, so it is raised on the edge that enters DONE.
        done_nxt = (state_nxt == DONE) && (state != DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_addr  <= '0;
            cap_hi    <= '0;
            data      <= '0;
            mem_done  <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cap_addr  <= cap_addr_nxt;
            cap_hi    <= cap_hi_nxt;
            data      <= data_nxt;
            mem_done  <= done_nxt;
            mem_req   <= req_nxt;
            mem_we    <= we_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            err       <= err_nxt;
        end
    end

endmodule
